// File: rtl/sprite_pkg.sv
// Shared state encoding, colour constants, default geometry and move-target helpers
// for the sprite mover.
package sprite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_DRAW   = 3'd2,
    ST_READY  = 3'd3,
    ST_ERASE  = 3'd4,
    ST_MOVE   = 3'd5,
    ST_REDRAW = 3'd6,
    ST_HOLD   = 3'd7
  } state_t;

  localparam int COLOUR_W = 3;
  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_SPRITE_W = 11;
  localparam int DEF_SPRITE_H = 10;

  // Integer arithmetic so a left move near 0 cannot underflow and a right move cannot wrap.
  function automatic logic [7:0] move_target(input logic [7:0] x, input logic go_right,
                                             input int step, input int max_x);
    int t;
    if (go_right) begin
      t = int'(x) + step;
      if (t > max_x) t = max_x;
    end else begin
      t = int'(x) - step;
      if (t < 0) t = 0;
    end
    return 8'(t);
  endfunction

  function automatic logic move_clamped(input logic [7:0] x, input logic go_right,
                                        input int step, input int max_x);
    if (go_right) return (int'(x) + step) > max_x;
    else return int'(x) < step;
  endfunction

endpackage

// File: rtl/box_scan.sv
// Row-major rectangle scanner: after a go pulse it emits one (x,y) per cycle over a
// width x height box at the latched origin; done marks the final pixel.
module box_scan
  import sprite_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_go,
  input  logic [7:0] i_org_x,
  input  logic [6:0] i_org_y,
  input  logic [7:0] i_width,
  input  logic [6:0] i_height,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic       o_valid,
  output logic       o_done
);

  logic [7:0] r_ox, r_w, r_col;
  logic [6:0] r_oy, r_h, r_row;
  logic       r_active;
  logic       w_last_col, w_last_row;

  assign w_last_col = (r_col == r_w - 8'd1);
  assign w_last_row = (r_row == r_h - 7'd1);
  assign o_x     = r_ox + r_col;
  assign o_y     = r_oy + r_row;
  assign o_valid = r_active;
  assign o_done  = r_active && w_last_col && w_last_row;

  // go wins over finishing so a new box can start on the last pixel of the previous one
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ox <= 8'd0; r_oy <= 7'd0; r_w <= 8'd0; r_h <= 7'd0;
      r_col <= 8'd0; r_row <= 7'd0; r_active <= 1'b0;
    end else if (i_go) begin
      r_ox <= i_org_x; r_oy <= i_org_y; r_w <= i_width; r_h <= i_height;
      r_col <= 8'd0; r_row <= 7'd0; r_active <= 1'b1;
    end else if (r_active) begin
      if (w_last_col) begin
        r_col <= 8'd0;
        if (w_last_row) begin
          r_row    <= 7'd0;
          r_active <= 1'b0;
        end else begin
          r_row <= r_row + 7'd1;
        end
      end else begin
        r_col <= r_col + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// Clears the screen, draws a ROM sprite on a fixed row and moves it left/right on request.
// Build option: define SPRITE_TRANSPARENT_EN to suppress plots of BLACK sprite pixels.
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int SPRITE_W    = DEF_SPRITE_W,
  parameter int SPRITE_H    = DEF_SPRITE_H,
  parameter int X_START     = 73,
  parameter int Y_START     = 105,
  parameter int STEP        = 5,
  parameter int HOLD_CYCLES = 5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   left,
  input  logic                                   right,
  output logic [$clog2(SPRITE_W*SPRITE_H)-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0]                    rom_q,
  output logic [7:0]                             xout,
  output logic [6:0]                             yout,
  output logic [COLOUR_W-1:0]                    colour_out,
  output logic                                   plot,
  output logic                                   busy,
  output logic                                   at_edge,
  output logic [7:0]                             xpos
);

  localparam int AW    = $clog2(SPRITE_W * SPRITE_H);
  localparam int MAX_X = SCREEN_W - SPRITE_W;
  localparam int HW    = $clog2(HOLD_CYCLES + 1);

  state_t        r_state;
  logic [7:0]    r_xpos, r_target, r_xout;
  logic [6:0]    r_yout;
  logic [AW-1:0] r_rom_addr;
  logic [HW-1:0] r_hold;
  logic          r_clamped, r_smode, r_busy, r_at_edge, r_plot, r_out_sprite, r_pdone;

  logic          w_go, w_go_sprite, w_sv, w_sdone, w_req, w_clamp, w_move;
  logic [7:0]    w_org_x, w_box_w, w_sx, w_tgt;
  logic [6:0]    w_org_y, w_box_h, w_sy;

  box_scan u_scan (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_go     (w_go),
    .i_org_x  (w_org_x),
    .i_org_y  (w_org_y),
    .i_width  (w_box_w),
    .i_height (w_box_h),
    .o_x      (w_sx),
    .o_y      (w_sy),
    .o_valid  (w_sv),
    .o_done   (w_sdone)
  );

  assign w_req   = left ^ right;
  assign w_tgt   = move_target(r_xpos, right, STEP, MAX_X);
  assign w_clamp = move_clamped(r_xpos, right, STEP, MAX_X);
  assign w_move  = (r_state == ST_READY) && w_req && (w_tgt != r_xpos);

  // colour comes straight from the ROM's registered data, which lines up with the delayed x/y/plot
  assign colour_out = r_out_sprite ? rom_q : BLACK;
`ifdef SPRITE_TRANSPARENT_EN
  assign plot = r_plot && !(r_out_sprite && (rom_q == BLACK));
`else
  assign plot = r_plot;
`endif
  assign rom_addr = r_rom_addr;
  assign xout     = r_xout;
  assign yout     = r_yout;
  assign busy     = r_busy;
  assign at_edge  = r_at_edge;
  assign xpos     = r_xpos;

  // Scanner launch: box origin/size and whether the pixels come from the sprite ROM
  always_comb begin
    w_go        = 1'b0;
    w_go_sprite = 1'b0;
    w_org_x     = r_xpos;
    w_org_y     = 7'(Y_START);
    w_box_w     = 8'(SPRITE_W);
    w_box_h     = 7'(SPRITE_H);
    case (r_state)
      ST_IDLE: begin
        w_go    = start;
        w_org_x = 8'd0;
        w_org_y = 7'd0;
        w_box_w = 8'(SCREEN_W);
        w_box_h = 7'(SCREEN_H);
      end
      ST_CLEAR: begin
        w_go        = r_pdone;
        w_go_sprite = 1'b1;
      end
      ST_READY: w_go = w_move;
      ST_MOVE: begin
        w_go        = 1'b1;
        w_go_sprite = 1'b1;
        w_org_x     = r_target;
      end
      default: w_go = 1'b0;
    endcase
  end

  // Controller, one-stage pixel pipeline and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;       r_xpos <= 8'(X_START);  r_target <= 8'd0;
      r_clamped <= 1'b0;        r_smode <= 1'b0;        r_rom_addr <= '0;
      r_hold <= '0;             r_busy <= 1'b0;         r_at_edge <= 1'b0;
      r_xout <= 8'd0;           r_yout <= 7'd0;         r_plot <= 1'b0;
      r_out_sprite <= 1'b0;     r_pdone <= 1'b0;
    end else begin
      r_at_edge    <= 1'b0;
      r_xout       <= w_sx;
      r_yout       <= w_sy;
      r_plot       <= w_sv;
      r_out_sprite <= w_sv && r_smode;
      r_pdone      <= w_sdone;
      if (w_go) r_smode <= w_go_sprite;
      if (w_go) r_rom_addr <= '0;
      else if (w_sv && r_smode) r_rom_addr <= w_sdone ? '0 : r_rom_addr + 1'b1;

      // each scan state exits once its final pixel has left the pipeline
      case (r_state)
        ST_IDLE: if (start) begin
          r_state <= ST_CLEAR;
          r_busy  <= 1'b1;
        end
        ST_CLEAR: if (r_pdone) r_state <= ST_DRAW;
        ST_DRAW: if (r_pdone) begin
          r_state <= ST_READY;
          r_busy  <= 1'b0;
        end
        ST_READY: if (w_req) begin
          if (w_tgt == r_xpos) begin
            r_at_edge <= 1'b1;
          end else begin
            r_state   <= ST_ERASE;
            r_busy    <= 1'b1;
            r_target  <= w_tgt;
            r_clamped <= w_clamp;
          end
        end
        ST_ERASE: if (r_pdone) r_state <= ST_MOVE;
        ST_MOVE: begin
          r_xpos    <= r_target;
          r_at_edge <= r_clamped;
          r_state   <= ST_REDRAW;
        end
        ST_REDRAW: if (r_pdone) begin
          r_state <= ST_HOLD;
          r_hold  <= '0;
        end
        ST_HOLD: begin
          if (r_hold == HW'(HOLD_CYCLES - 1)) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed self-checking bench for sprite_mover: clear, draw, moves, clamps, refusals, reset abort.
module tb_sprite_mover;

  localparam int SW = 160, SH = 120, PW = 11, PH = 10, YS = 105;
`ifdef SPRITE_TRANSPARENT_EN
  localparam int EXP_DRAW = 90;
`else
  localparam int EXP_DRAW = 110;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, left = 1'b0, right = 1'b0;
  logic [6:0] rom_addr;
  logic [2:0] rom_q;
  logic [7:0] xout, xpos;
  logic [6:0] yout;
  logic [2:0] colour_out;
  logic       plot, busy, at_edge;
  logic [2:0] rom_mem [0:PW*PH-1];

  int n_pass = 0, n_chk = 0;
  int pc, bad, minx, maxx, miny, maxy, ae_cnt, ae_x, busy_hi;
  logic smode;
  int ox, oy, bw, bh;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_q <= rom_mem[rom_addr];

  sprite_mover dut (
    .clk(clk), .reset(reset), .start(start), .left(left), .right(right),
    .rom_addr(rom_addr), .rom_q(rom_q), .xout(xout), .yout(yout),
    .colour_out(colour_out), .plot(plot), .busy(busy), .at_edge(at_edge), .xpos(xpos)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clr(input logic m, input int x0, input int y0, input int w, input int h);
    smode = m; ox = x0; oy = y0; bw = w; bh = h;
    pc = 0; bad = 0; minx = 999; maxx = -1; miny = 999; maxy = -1;
    ae_cnt = 0; ae_x = -1; busy_hi = 0;
  endtask

  task automatic step();
    int dx, dy;
    @(posedge clk); #1;
    if (at_edge) begin ae_cnt++; ae_x = int'(xpos); end
    if (busy) busy_hi++;
    if (plot) begin
      dx = int'(xout) - ox;
      dy = int'(yout) - oy;
      if (smode) begin
        if (dx < 0 || dx >= bw || dy < 0 || dy >= bh) bad++;
        else if (colour_out != rom_mem[dy*bw + dx]) bad++;
      end else begin
        if (dx != pc % bw || dy != pc / bw || colour_out != 3'd0) bad++;
      end
      pc++;
      if (int'(xout) < minx) minx = int'(xout);
      if (int'(xout) > maxx) maxx = int'(xout);
      if (int'(yout) < miny) miny = int'(yout);
      if (int'(yout) > maxy) maxy = int'(yout);
    end
  endtask

  task automatic wait_plots(input int n, input int budget, input string tag);
    int c = 0;
    while (pc < n && c < budget) begin step(); c++; end
    chk({tag, "_reached"}, int'(pc >= n), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while (busy && c < budget) begin step(); c++; end
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic hold_until(input logic go_right, input int x, input int budget, input string tag);
    int c = 0;
    left = !go_right; right = go_right;
    while (int'(xpos) != x && c < budget) begin step(); c++; end
    left = 1'b0; right = 1'b0;
    wait_idle(600, tag);
    chk({tag, "_xpos"}, int'(xpos), x);
  endtask

  initial begin
    for (int i = 0; i < PW*PH; i++) rom_mem[i] = (i < 20) ? 3'd0 : 3'(i % 7 + 1);
    clr(1'b0, 0, 0, SW, SH);
    step(); step();
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_xpos", int'(xpos), 73);
    chk("rst_xout", int'(xout), 0);
    chk("rst_yout", int'(yout), 0);
    chk("rst_colour", int'(colour_out), 0);
    chk("rst_at_edge", int'(at_edge), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    reset = 1'b1;
    step(); step();
    chk("idle_no_plot", pc, 0);

    // screen clear followed by the initial sprite draw
    clr(1'b0, 0, 0, SW, SH);
    start = 1'b1; step(); start = 1'b0;
    chk("clear_busy", int'(busy), 1);
    wait_plots(SW*SH, SW*SH + 100, "clear");
    chk("clear_count", pc, 19200);
    chk("clear_bad", bad, 0);
    chk("clear_maxx", maxx, 159);
    chk("clear_maxy", maxy, 119);
    clr(1'b1, 73, YS, PW, PH);
    wait_idle(300, "draw");
    chk("draw_count", pc, EXP_DRAW);
    chk("draw_bad", bad, 0);
    chk("draw_minx", minx, 73);
    chk("draw_maxx", maxx, 83);
    chk("draw_miny", miny, 105);
    chk("draw_maxy", maxy, 114);
    chk("draw_cycles", busy_hi, 111);

    // one right move: erase, move, redraw, hold
    clr(1'b0, 73, YS, PW, PH);
    right = 1'b1; step(); right = 1'b0;
    wait_plots(110, 200, "erase");
    chk("erase_count", pc, 110);
    chk("erase_bad", bad, 0);
    chk("erase_maxx", maxx, 83);
    clr(1'b1, 78, YS, PW, PH);
    wait_plots(EXP_DRAW, 200, "redraw");
    chk("redraw_count", pc, EXP_DRAW);
    chk("redraw_bad", bad, 0);
    chk("redraw_minx", minx, 78);
    chk("redraw_maxx", maxx, 88);
    chk("move_xpos", int'(xpos), 78);
    chk("move_no_edge", ae_cnt, 0);
    clr(1'b1, 78, YS, PW, PH);
    wait_idle(50, "hold");
    chk("hold_cycles", busy_hi, 5);
    chk("hold_no_plot", pc, 0);

    // held key repeats; then right clamp and refusal
    hold_until(1'b1, 148, 5000, "rep_right");
    clr(1'b0, 148, YS, PW, PH);
    right = 1'b1; step(); right = 1'b0;
    wait_idle(600, "clamp_r");
    chk("clamp_r_xpos", int'(xpos), 149);
    chk("clamp_r_edge_cnt", ae_cnt, 1);
    chk("clamp_r_edge_x", ae_x, 149);
    chk("clamp_r_maxx", maxx, 159);
    clr(1'b0, 0, 0, 1, 1);
    right = 1'b1; step(); right = 1'b0;
    repeat (4) step();
    chk("refuse_r_edge", ae_cnt, 1);
    chk("refuse_r_plots", pc, 0);
    chk("refuse_r_busy", busy_hi, 0);
    clr(1'b0, 0, 0, 1, 1);
    left = 1'b1; right = 1'b1;
    repeat (4) step();
    left = 1'b0; right = 1'b0;
    step();
    chk("both_edge", ae_cnt, 0);
    chk("both_plots", pc, 0);
    chk("both_busy", busy_hi, 0);
    chk("both_xpos", int'(xpos), 149);

    // left clamp and refusal
    hold_until(1'b0, 4, 9000, "rep_left");
    clr(1'b0, 4, YS, PW, PH);
    left = 1'b1; step(); left = 1'b0;
    wait_idle(600, "clamp_l");
    chk("clamp_l_xpos", int'(xpos), 0);
    chk("clamp_l_edge_cnt", ae_cnt, 1);
    chk("clamp_l_edge_x", ae_x, 0);
    chk("clamp_l_minx", minx, 0);
    clr(1'b0, 0, 0, 1, 1);
    left = 1'b1; step(); left = 1'b0;
    repeat (4) step();
    chk("refuse_l_edge", ae_cnt, 1);
    chk("refuse_l_plots", pc, 0);
    chk("refuse_l_busy", busy_hi, 0);

    // reset in the middle of a redraw
    clr(1'b0, 0, YS, PW, PH);
    right = 1'b1; step(); right = 1'b0;
    wait_plots(110, 200, "abort_erase");
    clr(1'b1, 5, YS, PW, PH);
    wait_plots(50, 200, "abort_redraw");
    reset = 1'b0;
    step();
    chk("abort_plot", int'(plot), 0);
    chk("abort_xpos", int'(xpos), 73);
    chk("abort_busy", int'(busy), 0);
    reset = 1'b1;
    clr(1'b0, 0, 0, 1, 1);
    repeat (5) step();
    chk("abort_idle_plots", pc, 0);
    chk("abort_idle_busy", busy_hi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- SPRITE_W, 11, sprite width.
- SPRITE_H, 10, sprite height.
- X_START, 73, home x.
- Y_START, 105, home y (fixed row).
- STEP, 5, pixels per move.
- HOLD_CYCLES, 5, cooldown after each move.
REQ-002 Ports (name, direction, width, meaning), one per line; one clock; reset is synchronous and active-low:
- clk  in  1  clock.
- reset  in  1  synchronous active-low reset.
- start  in  1  leave IDLE.
- left  in  1  move-left request, level.
- right  in  1  move-right request, level.
- rom_addr  out  clog2(SPRITE_W*SPRITE_H)  sprite ROM address.
- rom_q  in  3  ROM colour, valid 1 cycle after rom_addr.
- xout  out  8  pixel x.
- yout  out  7  pixel y.
- colour_out  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  high in every state except IDLE and READY.
- at_edge  out  1  one-cycle pulse when a move was clamped or refused.
- xpos  out  8  current sprite left x.

Function
REQ-003 FSM states: IDLE, CLEAR, DRAW, READY, ERASE, MOVE, REDRAW, HOLD.
REQ-004 IDLE->CLEAR on start; CLEAR->DRAW after the last screen pixel; DRAW->READY after the last sprite pixel.
REQ-005 CLEAR SHALL raster x 0..SCREEN_W-1 within y 0..SCREEN_H-1, colour 0, plot=1, one pixel per cycle, SCREEN_W*SCREEN_H cycles.
REQ-006 DRAW/REDRAW SHALL raster the SPRITE_W x SPRITE_H box at (xpos,Y_START), row-major; rom_addr=row*SPRITE_W+col; x/y/plot delayed one stage to align with rom_q; duration SPRITE_W*SPRITE_H+1 cycles.
REQ-007 In READY: left XOR right SHALL start a move; both or neither SHALL hold READY.
REQ-008 Target left = max(xpos-STEP,0); target right = min(xpos+STEP,SCREEN_W-SPRITE_W); no signed underflow or 8-bit wrap is permitted.
REQ-009 Target==xpos: at_edge pulse, FSM stays READY, no pixels plotted.
REQ-010 Target!=xpos: READY->ERASE (old box, colour 0) ->MOVE (1 cycle, xpos<=target, at_edge pulses if clamped) ->REDRAW->HOLD.
REQ-011 HOLD SHALL last HOLD_CYCLES cycles, ignoring left/right, then go to READY; a held key repeats one move per pass.
REQ-012 plot=0 in IDLE, READY, MOVE and HOLD.

Reset
REQ-013 reset=0 at a clk edge: state IDLE, xpos=X_START, xout=0, yout=0, colour_out=0, plot=0, at_edge=0, busy=0, rom_addr=0, scan counters 0.
REQ-014 Reset mid-CLEAR/ERASE/REDRAW SHALL abort with no further plot in the following cycle.

Configuration
REQ-015 Macro SPRITE_TRANSPARENT_EN defined: DRAW/REDRAW pixels with rom_q==3'b000 SHALL have plot=0. Undefined: every sprite pixel plots. CLEAR and ERASE are unaffected.

Structure
REQ-016 Package sprite_pkg SHALL hold the state enum, COLOUR_W=3, BLACK=3'b000, and the default screen/sprite dimensions.
REQ-017 A sub-module box_scan (origin, width, height, go -> x, y, valid, done) SHALL be shared by CLEAR, ERASE and REDRAW.

Verification
REQ-018 Defaults, start pulse -> 19200 plots colour 0, then 110 sprite plots at x 73..83, y 105..114; READY.
REQ-019 READY, right for 1 cycle -> 110 erase plots at x 73..83, xpos=78, 110 draw plots at x 78..88, busy then 5 HOLD cycles.
REQ-020 xpos=3, left -> xpos=0, at_edge pulse in MOVE; next left -> at_edge pulse, no plots, stays READY.
REQ-021 xpos=147, right -> xpos=149 (=160-11), at_edge pulse; left and right together -> no action.
REQ-022 reset=0 at pixel 50 of REDRAW -> next cycle plot=0, xpos=73, state IDLE.
REQ-023 SPRITE_TRANSPARENT_EN with a ROM holding 20 zero entries -> exactly 90 plots per DRAW.
